// File: rtl/mux_alub_pipe_pkg.sv
// Shared definitions for the ALU operand-B pipeline: select codes and
// handshake occupancy states.
package mux_alub_defs;

  localparam logic [2:0] SEL_B       = 3'd0;
  localparam logic [2:0] SEL_CONST   = 3'd1;
  localparam logic [2:0] SEL_IMM_SX  = 3'd2;
  localparam logic [2:0] SEL_IMM_SFT = 3'd3;
  localparam logic [2:0] SEL_IMM_ZX  = 3'd4;

  // State value is the number of operands held (M, then M+S).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_t;

endpackage

// File: rtl/mux_alub_pipe_operand_gen.sv
// Combinational operand-B former: picks register B, a constant, or an
// extended/shifted immediate, and flags select codes with no defined operand.
module alub_operand_gen
  import mux_alub_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  parameter int SHAMT     = 2
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] data_b,
  input  logic [IMM_W-1:0] imm,
  output logic [WIDTH-1:0] operand,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] CONST_OP = WIDTH'(CONST_VAL);

  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_zx;

  assign imm_sx = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zx = {{(WIDTH-IMM_W){1'b0}}, imm};

  // Illegal codes produce a zero operand so nothing stale reaches the ALU.
  always_comb begin
    operand = '0;
    illegal = 1'b0;
    case (sel)
      SEL_B:       operand = data_b;
      SEL_CONST:   operand = CONST_OP;
      SEL_IMM_SX:  operand = imm_sx;
      SEL_IMM_SFT: operand = imm_sx << SHAMT;
      SEL_IMM_ZX:  operand = imm_zx;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mux_alub_pipe.sv
// Pipelined ALU operand-B selector with a 2-entry skid buffer so the ALU
// stage can stall without dropping an operand; sticky illegal-select flag.
module mux_alub_pipe
  import mux_alub_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  parameter int SHAMT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] data_b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             sel_err,
  input  logic             clr_err
);

  state_t           state, state_n;
  logic [WIDTH-1:0] m_q, s_q;
  logic [WIDTH-1:0] operand;
  logic             illegal;
  logic             accept, consume;
  logic             load_m_op, load_m_s, load_s;
  logic             err_q;

  alub_operand_gen #(
    .WIDTH    (WIDTH),
    .IMM_W    (IMM_W),
    .CONST_VAL(CONST_VAL),
    .SHAMT    (SHAMT)
  ) u_gen (
    .sel    (sel),
    .data_b (data_b),
    .imm    (imm),
    .operand(operand),
    .illegal(illegal)
  );

  // Handshake flags are pure decodes of the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state != ST_FULL2);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign data_out  = m_q;
  assign sel_err   = err_q;

  always_comb begin
    state_n   = state;
    load_m_op = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n   = ST_FULL1;
          load_m_op = 1'b1;
        end
      end
      ST_FULL1: begin
        if (accept && consume) begin
          load_m_op = 1'b1;
        end else if (accept) begin
          state_n = ST_FULL2;
          load_s  = 1'b1;
        end else if (consume) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (consume) begin
          state_n  = ST_FULL1;
          load_m_s = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      state <= state_n;
      if (load_m_op) m_q <= operand;
      else if (load_m_s) m_q <= s_q;
      if (load_s) s_q <= operand;
    end
  end

  // A set from an accepted illegal select outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && illegal) begin
      err_q <= 1'b1;
    end else if (clr_err) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_alub_pipe.sv
// Directed self-checking bench for mux_alub_pipe: select decode, skid
// backpressure, streaming, sticky error, async reset and a narrow build.
module tb_mux_alub_pipe;
  import mux_alub_defs::*;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  sel;
  logic [31:0] data_b, data_out;
  logic [15:0] imm;
  logic        sel_err, clr_err;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [2:0]  p_sel;
  logic [15:0] p_data_b, p_data_out;
  logic [7:0]  p_imm;
  logic        p_sel_err, p_clr_err;

  int checks   = 0;
  int failures = 0;

  mux_alub_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .data_b   (data_b),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .sel_err  (sel_err),
    .clr_err  (clr_err)
  );

  mux_alub_pipe #(
    .WIDTH    (16),
    .IMM_W    (8),
    .CONST_VAL(2),
    .SHAMT    (1)
  ) dut_p (
    .clk      (clk),
    .reset    (reset),
    .in_valid (p_in_valid),
    .in_ready (p_in_ready),
    .sel      (p_sel),
    .data_b   (p_data_b),
    .imm      (p_imm),
    .out_valid(p_out_valid),
    .out_ready(p_out_ready),
    .data_out (p_data_out),
    .sel_err  (p_sel_err),
    .clr_err  (p_clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sel_exp [5];
    sel_exp[0] = 32'h12345678;
    sel_exp[1] = 32'h00000004;
    sel_exp[2] = 32'hFFFF8001;
    sel_exp[3] = 32'hFFFE0004;
    sel_exp[4] = 32'h00008001;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; sel = SEL_B;
    data_b = 32'h12345678; imm = 16'h8001; clr_err = 1'b0;
    p_in_valid = 1'b0; p_out_ready = 1'b1; p_sel = SEL_B;
    p_data_b = 16'h0; p_imm = 8'hC0; p_clr_err = 1'b0;

    #12;
    check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("rst_data_out", data_out, 32'd0);
    check_output("rst_sel_err", {31'b0, sel_err}, 32'd0);
    reset = 1'b0;
    $display("[TB] select decode");

    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sel = 3'(k);
      step();
      check_output($sformatf("sel%0d_valid", k), {31'b0, out_valid}, 32'd1);
      check_output($sformatf("sel%0d_data", k), data_out, sel_exp[k]);
    end
    in_valid = 1'b0;
    step();
    check_output("sel_drain_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0; in_valid = 1'b1; sel = SEL_B; data_b = 32'hAAAA0001;
    step();
    check_output("bp_a_data", data_out, 32'hAAAA0001);
    check_output("bp_a_in_ready", {31'b0, in_ready}, 32'd1);
    data_b = 32'hBBBB0002;
    step();
    check_output("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    check_output("bp_hold_a", data_out, 32'hAAAA0001);
    data_b = 32'hCCCC0003;
    step();
    check_output("bp_ignore_c", data_out, 32'hAAAA0001);
    check_output("bp_still_full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_output("bp_b_data", data_out, 32'hBBBB0002);
    check_output("bp_b_valid", {31'b0, out_valid}, 32'd1);
    step();
    check_output("bp_empty_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] streaming");
    in_valid = 1'b1; sel = SEL_B;
    for (int i = 0; i < 10; i++) begin
      data_b = 32'd100 + 32'(i);
      step();
      check_output($sformatf("st%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check_output($sformatf("st%0d_data", i), data_out, 32'd100 + 32'(i));
      check_output($sformatf("st%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_output("st_drain_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] illegal select");
    in_valid = 1'b0; sel = 3'd5;
    step();
    check_output("ill_unaccepted", {31'b0, sel_err}, 32'd0);
    in_valid = 1'b1; sel = 3'd6; data_b = 32'h0BADBEEF;
    step();
    check_output("ill_data_zero", data_out, 32'd0);
    check_output("ill_err_set", {31'b0, sel_err}, 32'd1);
    sel = SEL_B; data_b = 32'h00000055;
    step();
    check_output("ill_legal_data", data_out, 32'h00000055);
    check_output("ill_err_sticky", {31'b0, sel_err}, 32'd1);
    sel = 3'd7; clr_err = 1'b1;
    step();
    check_output("ill_set_wins", {31'b0, sel_err}, 32'd1);
    check_output("ill7_data_zero", data_out, 32'd0);
    in_valid = 1'b0; sel = 3'd5;
    step();
    check_output("ill_cleared", {31'b0, sel_err}, 32'd0);
    clr_err = 1'b0;
    step();

    $display("[TB] async reset in FULL2");
    out_ready = 1'b0; in_valid = 1'b1; sel = SEL_B; data_b = 32'h000000AA;
    step();
    data_b = 32'h000000BB;
    step();
    check_output("ar_full2", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("ar_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("ar_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("ar_data_out", data_out, 32'd0);
    #3 reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; sel = SEL_CONST;
    step();
    check_output("ar_first_accept", data_out, 32'h00000004);
    check_output("ar_first_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check_output("ar_no_leak", {31'b0, out_valid}, 32'd0);

    $display("[TB] narrow parameter build");
    p_in_valid = 1'b1; p_sel = SEL_IMM_SX;
    step();
    check_output("p_imm_sx", {16'b0, p_data_out}, 32'h0000FFC0);
    p_sel = SEL_IMM_SFT;
    step();
    check_output("p_imm_sft", {16'b0, p_data_out}, 32'h0000FF80);
    p_sel = SEL_CONST;
    step();
    check_output("p_const", {16'b0, p_data_out}, 32'h00000002);
    check_output("p_valid", {31'b0, p_out_valid}, 32'd1);
    p_in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
